// File: rtl/gng_stats_monitor_pkg.sv
// Shared FSM state type and width helpers for the gng statistics monitor.
package gng_stats_monitor_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_RUN,
    ST_DRAIN,
    ST_DONE
  } state_e;

  function automatic int unsigned sum_width(input int unsigned data_w, input int unsigned log2_n);
    return data_w + log2_n;
  endfunction

  function automatic int unsigned sumsq_width(input int unsigned data_w, input int unsigned log2_n);
    return 2 * data_w + log2_n;
  endfunction

  function automatic int unsigned cnt_width(input int unsigned max_val);
    return $clog2(max_val + 1);
  endfunction

endpackage

// File: rtl/gng_stats_monitor_acc.sv
// Two-stage statistics datapath: stage1 captures accepted samples, stage2
// squares and accumulates them and tracks the peak magnitude.
module gng_stats_acc
  import gng_stats_monitor_pkg::*;
#(
  parameter int unsigned DATA_W = 16,
  parameter int unsigned LOG2_N = 10
) (
  input  logic                         clk,
  input  logic                         rstn,
  input  logic                         clr,
  input  logic                         accept,
  input  logic [DATA_W-1:0]            data_in,
  output logic [DATA_W+LOG2_N-1:0]     sum,
  output logic [2*DATA_W+LOG2_N-1:0]   sumsq,
  output logic [DATA_W-1:0]            max_abs
);

  localparam int unsigned SUM_W  = sum_width(DATA_W, LOG2_N);
  localparam int unsigned SQ_W   = sumsq_width(DATA_W, LOG2_N);
  localparam int unsigned PROD_W = 2 * DATA_W;

  logic                     s1_valid_q, s1_valid_d;
  logic [DATA_W-1:0]        s1_data_q, s1_data_d;
  logic [SUM_W-1:0]         sum_q, sum_d;
  logic [SQ_W-1:0]          sumsq_q, sumsq_d;
  logic [DATA_W-1:0]        max_abs_q, max_abs_d;
  logic signed [PROD_W-1:0] x_ext;
  logic [PROD_W-1:0]        square;
  logic [DATA_W-1:0]        abs_x;

  always_comb begin
    s1_valid_d = accept & ~clr;
    s1_data_d  = accept ? data_in : s1_data_q;

    x_ext  = {{DATA_W{s1_data_q[DATA_W-1]}}, s1_data_q};
    square = x_ext * x_ext;
    // Unsigned magnitude: -2**(DATA_W-1) maps to 2**(DATA_W-1), which fits.
    abs_x  = s1_data_q[DATA_W-1] ? (~s1_data_q + DATA_W'(1)) : s1_data_q;

    sum_d     = sum_q;
    sumsq_d   = sumsq_q;
    max_abs_d = max_abs_q;
    if (clr) begin
      sum_d     = '0;
      sumsq_d   = '0;
      max_abs_d = '0;
    end else if (s1_valid_q) begin
      sum_d   = sum_q + {{LOG2_N{s1_data_q[DATA_W-1]}}, s1_data_q};
      sumsq_d = sumsq_q + {{LOG2_N{1'b0}}, square};
      if (abs_x > max_abs_q) max_abs_d = abs_x;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      s1_valid_q <= 1'b0;
      s1_data_q  <= '0;
      sum_q      <= '0;
      sumsq_q    <= '0;
      max_abs_q  <= '0;
    end else begin
      s1_valid_q <= s1_valid_d;
      s1_data_q  <= s1_data_d;
      sum_q      <= sum_d;
      sumsq_q    <= sumsq_d;
      max_abs_q  <= max_abs_d;
    end
  end

  assign sum     = sum_q;
  assign sumsq   = sumsq_q;
  assign max_abs = max_abs_q;

endmodule

// File: rtl/gng_stats_monitor.sv
// Window controller for the gng self-test: requests 2**LOG2_N samples via ce,
// counts returns, detects stalls and reports sum / sum of squares / peak.
module gng_stats_monitor
  import gng_stats_monitor_pkg::*;
#(
  parameter int unsigned DATA_W  = 16,
  parameter int unsigned LOG2_N  = 10,
  parameter int unsigned MAX_LAT = 8
) (
  input  logic                         clk,
  input  logic                         rstn,
  input  logic                         start,
  output logic                         ce,
  input  logic                         valid_in,
  input  logic [DATA_W-1:0]            data_in,
  output logic                         busy,
  output logic                         done,
  output logic [DATA_W+LOG2_N-1:0]     sum,
  output logic [2*DATA_W+LOG2_N-1:0]   sumsq,
  output logic [DATA_W-1:0]            max_abs,
  output logic                         timeout_err
);

  localparam int unsigned CNT_W  = LOG2_N + 1;
  localparam int unsigned IDLE_W = cnt_width(MAX_LAT);
  localparam logic [CNT_W-1:0]  N_C      = CNT_W'(2 ** LOG2_N);
  localparam logic [IDLE_W-1:0] LAT_LAST = IDLE_W'(MAX_LAT - 1);

  state_e            state_q, state_d;
  logic [CNT_W-1:0]  req_cnt_q, req_cnt_d;
  logic [CNT_W-1:0]  rx_cnt_q, rx_cnt_d;
  logic [IDLE_W-1:0] idle_cnt_q, idle_cnt_d;
  logic              timeout_q, timeout_d;
  logic              clr;
  logic              accept;

  always_comb begin
    state_d    = state_q;
    req_cnt_d  = req_cnt_q;
    rx_cnt_d   = rx_cnt_q;
    idle_cnt_d = idle_cnt_q;
    timeout_d  = timeout_q;
    clr        = 1'b0;
    ce         = 1'b0;
    busy       = 1'b1;
    done       = 1'b0;

    accept = valid_in && (state_q == ST_RUN || state_q == ST_DRAIN) && (rx_cnt_q != N_C);
    if (accept) rx_cnt_d = rx_cnt_q + CNT_W'(1);

    unique case (state_q)
      ST_IDLE: begin
        busy = 1'b0;
        if (start) begin
          state_d    = ST_RUN;
          clr        = 1'b1;
          req_cnt_d  = '0;
          rx_cnt_d   = '0;
          idle_cnt_d = '0;
          timeout_d  = 1'b0;
        end
      end
      ST_RUN: begin
        ce        = 1'b1;
        req_cnt_d = req_cnt_q + CNT_W'(1);
        if (req_cnt_d == N_C) state_d = ST_DRAIN;
      end
      ST_DRAIN: begin
        // Stage1 can only hold sample N here and is absorbed on this same edge.
        if (rx_cnt_q == N_C) begin
          state_d = ST_DONE;
        end else if (valid_in) begin
          idle_cnt_d = '0;
        end else begin
          idle_cnt_d = idle_cnt_q + IDLE_W'(1);
          if (idle_cnt_q == LAT_LAST) begin
            timeout_d = 1'b1;
            state_d   = ST_DONE;
          end
        end
      end
      ST_DONE: begin
        done    = 1'b1;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q    <= ST_IDLE;
      req_cnt_q  <= '0;
      rx_cnt_q   <= '0;
      idle_cnt_q <= '0;
      timeout_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      req_cnt_q  <= req_cnt_d;
      rx_cnt_q   <= rx_cnt_d;
      idle_cnt_q <= idle_cnt_d;
      timeout_q  <= timeout_d;
    end
  end

  assign timeout_err = timeout_q;

  gng_stats_acc #(
    .DATA_W (DATA_W),
    .LOG2_N (LOG2_N)
  ) u_acc (
    .clk     (clk),
    .rstn    (rstn),
    .clr     (clr),
    .accept  (accept),
    .data_in (data_in),
    .sum     (sum),
    .sumsq   (sumsq),
    .max_abs (max_abs)
  );

endmodule

// File: tb/tb_gng_stats_monitor.sv
// Scoreboard bench for gng_stats_monitor with a latency-configurable gng driver model.
module tb_gng_stats_monitor;

  localparam int DATA_W  = 16;
  localparam int LOG2_N  = 2;
  localparam int MAX_LAT = 8;
  localparam int N       = 4;
  localparam int SUM_W   = DATA_W + LOG2_N;
  localparam int SQ_W    = 2 * DATA_W + LOG2_N;

  logic              clk = 1'b0;
  logic              rstn = 1'b0;
  logic              start = 1'b0;
  logic              ce;
  logic              valid_in = 1'b0;
  logic [DATA_W-1:0] data_in = '0;
  logic              busy;
  logic              done;
  logic [SUM_W-1:0]  sum;
  logic [SQ_W-1:0]   sumsq;
  logic [DATA_W-1:0] max_abs;
  logic              timeout_err;

  gng_stats_monitor #(
    .DATA_W  (DATA_W),
    .LOG2_N  (LOG2_N),
    .MAX_LAT (MAX_LAT)
  ) dut (
    .clk         (clk),
    .rstn        (rstn),
    .start       (start),
    .ce          (ce),
    .valid_in    (valid_in),
    .data_in     (data_in),
    .busy        (busy),
    .done        (done),
    .sum         (sum),
    .sumsq       (sumsq),
    .max_abs     (max_abs),
    .timeout_err (timeout_err)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int failures = 0;

  task automatic chk(input string name, input logic signed [63:0] act, input logic signed [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  typedef struct {
    longint sum;
    longint sumsq;
    int     maxabs;
    bit     tout;
  } exp_t;

  exp_t sb[$];

  // Driver model: answers each ce after `lat` cycles unless dropped.
  typedef struct {
    int due;
    int d;
  } pend_t;

  int         pat[N];
  int         wdata[N];
  int         lat = 0;
  bit [N-1:0] drop_mask = '0;
  int         extra_cnt = 0;
  bit         junk_en = 1'b0;
  int         ce_ord = 0;
  int         n_deliv = 0;
  int         nth_cyc = -1;
  int         last_valid_cyc = -1;
  int         last_ce_cyc = -1;
  pend_t      pend[$];

  initial begin
    pend_t p;
    forever begin
      @(negedge clk);
      valid_in = 1'b0;
      data_in  = DATA_W'($urandom);
      if (ce === 1'b1) begin
        last_ce_cyc = cyc;
        if (ce_ord < N) begin
          if (!drop_mask[ce_ord]) pend.push_back('{cyc + lat, wdata[ce_ord]});
        end
        ce_ord++;
      end
      if (pend.size() > 0 && pend[0].due == cyc) begin
        p = pend.pop_front();
        valid_in = 1'b1;
        data_in  = DATA_W'(p.d);
      end else if (extra_cnt > 0 && pend.size() == 0 && ce_ord >= N) begin
        valid_in = 1'b1;
        extra_cnt--;
      end else if (junk_en && busy === 1'b0) begin
        valid_in = 1'b1;
      end
      if (valid_in && busy === 1'b1) begin
        n_deliv++;
        last_valid_cyc = cyc;
        if (n_deliv == N) nth_cyc = cyc;
      end
    end
  end

  // Monitor: pops the scoreboard on every done pulse.
  int done_cnt = 0;
  int ce_cnt = 0;

  initial begin
    exp_t cur;
    int   exp_done;
    forever begin
      @(negedge clk);
      if (ce === 1'b1) ce_cnt++;
      if (done === 1'b1) begin
        done_cnt++;
        if (sb.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL unexpected_done: got done=1 at cycle %0d expected no pending window", cyc);
        end else begin
          cur = sb.pop_front();
          chk("sum", $signed(sum), cur.sum);
          chk("sumsq", sumsq, cur.sumsq);
          chk("max_abs", max_abs, cur.maxabs);
          chk("timeout_err", timeout_err, cur.tout);
          if (cur.tout)
            exp_done = ((last_valid_cyc > last_ce_cyc) ? last_valid_cyc : last_ce_cyc) + MAX_LAT + 1;
          else
            exp_done = nth_cyc + 2;
          chk("done_cycle", cyc, exp_done);
        end
      end
    end
  end

  task automatic cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic configure(input int l, input bit [N-1:0] drop, input int extra);
    lat            = l;
    drop_mask      = drop;
    extra_cnt      = extra;
    wdata          = pat;
    ce_ord         = 0;
    n_deliv        = 0;
    nth_cyc        = -1;
    last_valid_cyc = -1;
    last_ce_cyc    = -1;
    pend.delete();
  endtask

  task automatic check_all_zero(input string tag);
    chk({tag, "_ce"}, ce, 0);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_done"}, done, 0);
    chk({tag, "_sum"}, $signed(sum), 0);
    chk({tag, "_sumsq"}, sumsq, 0);
    chk({tag, "_max_abs"}, max_abs, 0);
    chk({tag, "_timeout_err"}, timeout_err, 0);
  endtask

  task automatic run_window(input int l, input bit [N-1:0] drop, input int extra, input bit restart);
    exp_t e;
    int   cnt;
    int   a;
    e = '{0, 0, 0, 1'b0};
    cnt = 0;
    for (int unsigned i = 0; i < N; i++) begin
      if (!drop[i]) begin
        e.sum   += pat[i];
        e.sumsq += longint'(pat[i]) * longint'(pat[i]);
        a = (pat[i] < 0) ? -pat[i] : pat[i];
        if (a > e.maxabs) e.maxabs = a;
        cnt++;
      end
    end
    e.tout = (cnt < N);

    @(negedge clk);
    configure(l, drop, extra);
    @(negedge clk);
    start    = 1'b1;
    done_cnt = 0;
    ce_cnt   = 0;
    sb.push_back(e);
    @(negedge clk);
    start = 1'b0;
    if (restart) begin
      @(negedge clk);
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
    end
    cnt = 0;
    while (done_cnt == 0 && cnt < 200) begin
      @(negedge clk);
      cnt++;
    end
    if (done_cnt == 0) begin
      checks++;
      failures++;
      $display("FAIL done_wait: got no done within 200 cycles expected one pulse");
      sb.delete();
    end
    cycles(4);
    chk("done_pulses", done_cnt, 1);
    chk("ce_cycles", ce_cnt, N);
    chk("busy_after", busy, 0);
    chk("hold_sum", $signed(sum), e.sum);
    chk("hold_timeout_err", timeout_err, e.tout);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got simulation still running expected completion");
    $fatal(1);
  end

  initial begin
    bit [N-1:0] dm;
    int         ex;

    cycles(3);
    check_all_zero("reset");
    rstn = 1'b1;
    cycles(2);

    pat = '{1, -2, 3, -4};
    run_window(3, '0, 0, 1'b0);

    pat = '{-32768, -32768, -32768, -32768};
    run_window(2, '0, 0, 1'b0);

    pat = '{100, -200, 300, -400};
    run_window(3, 4'b1111, 0, 1'b0);
    run_window(3, 4'b1100, 0, 1'b0);

    pat = '{7, -9, 11, -13};
    run_window(3, '0, 2, 1'b1);

    // Reset mid-window after some samples have accumulated.
    pat = '{1, -2, 3, -4};
    @(negedge clk);
    configure(0, '0, 0);
    @(negedge clk);
    start    = 1'b1;
    done_cnt = 0;
    @(negedge clk);
    start = 1'b0;
    cycles(2);
    chk("pre_reset_busy", busy, 1);
    chk("pre_reset_sum", $signed(sum), 1);
    rstn = 1'b0;
    #1;
    check_all_zero("midreset");
    cycles(2);
    rstn = 1'b1;
    cycles(6);
    chk("reset_no_done", done_cnt, 0);

    pat = '{1, -2, 3, -4};
    run_window(3, '0, 0, 1'b0);

    junk_en = 1'b1;
    for (int unsigned w = 0; w < 12; w++) begin
      for (int unsigned i = 0; i < N; i++) begin
        if ($urandom_range(0, 7) == 0) pat[i] = -32768;
        else pat[i] = int'($signed(DATA_W'($urandom)));
      end
      dm = ($urandom_range(0, 3) == 0) ? N'($urandom) : '0;
      ex = (dm == '0) ? int'($urandom_range(0, 2)) : 0;
      run_window(int'($urandom_range(0, 4)), dm, ex, 1'($urandom));
    end
    junk_en = 1'b0;

    cycles(3);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
